// File: rtl/bram_stream_reader.sv
// bram_stream_reader
// Read-side sequencer for port B of the FFT sample RAM. A START command
// walks LEN consecutive or bit-reversed addresses from BASE_ADDR. The RAM's
// one-cycle read latency is absorbed, and the words leave as a valid/ready
// stream with a LAST marker on the final word.
//
// Ports
//   clk_i, rst_n_i             clock, async active-low reset
//   start_i, base_addr_i,
//   len_i, bitrev_i            command, sampled only in IDLE
//   busy_o, done_o             command in progress / one-cycle completion
//   enb_o, web_o, addrb_o      RAM port-B controls (web_o tied low)
//   dob_i                      RAM port-B read data, valid cycle after enb_o
//   m_valid_o, m_ready_i,
//   m_data_o, m_last_o         output stream
//
// state  | meaning
// IDLE   | waiting for START
// READ   | issuing reads while the output buffer has room
// DRAIN  | all reads issued, waiting for the last word to be accepted
module bram_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int CMD_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [CMD_WIDTH-1:0]  base_addr_i,
    input  logic [CMD_WIDTH:0]    len_i,
    input  logic                  bitrev_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  enb_o,
    output logic                  web_o,
    output logic [CMD_WIDTH-1:0]  addrb_o,
    input  logic [DATA_WIDTH-1:0] dob_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic [CMD_WIDTH-1:0]    base_q;
    logic [CMD_WIDTH:0]      len_q;
    logic                    bitrev_q;
    logic [CMD_WIDTH:0]      idx_q;
    logic [CMD_WIDTH-1:0]    addr_q;
    logic                    rd_d1_q;
    logic                    last_d1_q;
    logic [DATA_WIDTH-1:0]   fifo_data_q [2];
    logic                    fifo_last_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              count_q;

    logic                    pop;
    logic                    issue;
    logic                    is_last_rd;
    logic                    accept;
    logic [CMD_WIDTH-1:0]    idx_rev;
    logic [CMD_WIDTH-1:0]    rd_addr;
    logic [2:0]              occ;

    always_comb begin
        idx_rev = '0;
        for (int b = 0; b < CMD_WIDTH; b++) begin
            idx_rev[CMD_WIDTH-1-b] = idx_q[b];
        end
    end

    assign rd_addr    = base_q + (bitrev_q ? idx_rev : idx_q[CMD_WIDTH-1:0]);
    assign m_valid_o  = (count_q != 2'd0);
    assign pop        = m_valid_o & m_ready_i;
    // Words that will sit in the buffer after this cycle; one more issue
    // is only allowed if that leaves a free slot for its data.
    assign occ        = {1'b0, count_q} + {2'b00, rd_d1_q} - {2'b00, pop};
    assign is_last_rd = (idx_q == len_q - (CMD_WIDTH+1)'(1));
    assign issue      = (state_q == S_READ) && (idx_q < len_q) && (occ <= 3'd1);
    assign accept     = (state_q == S_IDLE) && start_i && (len_i != '0);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) state_d = S_READ;
                    else             done_d  = 1'b1;
                end
            end
            S_READ: begin
                if (issue && is_last_rd) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && m_last_o) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            bitrev_q  <= 1'b0;
            idx_q     <= '0;
            addr_q    <= '0;
            rd_d1_q   <= 1'b0;
            last_d1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            rd_d1_q   <= issue;
            last_d1_q <= issue & is_last_rd;
            if (accept) begin
                base_q   <= base_addr_i;
                len_q    <= len_i;
                bitrev_q <= bitrev_i;
                idx_q    <= '0;
            end else if (issue) begin
                idx_q  <= idx_q + (CMD_WIDTH+1)'(1);
                addr_q <= rd_addr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
        end else begin
            if (rd_d1_q) begin
                fifo_data_q[wr_ptr_q] <= dob_i;
                fifo_last_q[wr_ptr_q] <= last_d1_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, rd_d1_q} - {1'b0, pop};
        end
    end

    assign enb_o    = issue;
    assign addrb_o  = issue ? rd_addr : addr_q;
    assign web_o    = 1'b0;
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = done_q;
    assign m_data_o = fifo_data_q[rd_ptr_q];
    assign m_last_o = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          bitrev;
    logic          busy, done, enb, web;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dob;
    logic          m_valid, m_ready, m_last;
    logic [DW-1:0] m_data;

    logic [DW-1:0] mem [16];

    int n_run  = 0;
    int n_fail = 0;

    logic [DW-1:0] got_data [$];
    bit            got_last [$];
    logic [AW-1:0] got_addr [$];
    int first_busy, first_enb, first_valid, last_cyc, done_cyc;
    int web_bad, unstable, ovf, stall_enb, n_enb, n_pop, valid_cnt;
    bit busy_at_done, timed_out;

    always #5 clk = ~clk;

    always @(posedge clk) if (enb) dob <= mem[addrb];

    bram_stream_reader #(.DATA_WIDTH(DW), .CMD_WIDTH(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .base_addr_i(base_addr),
        .len_i(len), .bitrev_i(bitrev), .busy_o(busy), .done_o(done),
        .enb_o(enb), .web_o(web), .addrb_o(addrb), .dob_i(dob),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
        .m_last_o(m_last)
    );

    // Reference: index k of a command maps to base + (k or k bit-reversed), mod 16.
    function automatic logic [AW-1:0] exp_addr(input int base, input bit brev, input int k);
        int r;
        r = 0;
        if (brev) begin
            for (int b = 0; b < AW; b++) if (((k >> b) & 1) != 0) r += (1 << (AW-1-b));
        end else begin
            r = k;
        end
        return AW'((base + r) % 16);
    endfunction

    function automatic int seq_errors(input int base, input int n, input bit brev);
        int e, lim;
        logic [AW-1:0] a;
        e = (got_data.size() > n) ? got_data.size() - n : n - got_data.size();
        if (got_addr.size() != n) e++;
        lim = (got_data.size() < n) ? got_data.size() : n;
        for (int k = 0; k < lim; k++) begin
            a = exp_addr(base, brev, k);
            if (got_data[k] !== mem[a]) e++;
            if (got_last[k] !== (k == n-1)) e++;
        end
        lim = (got_addr.size() < n) ? got_addr.size() : n;
        for (int k = 0; k < lim; k++) if (got_addr[k] !== exp_addr(base, brev, k)) e++;
        return e;
    endfunction

    function automatic bit ready_for(input int mode, input int c);
        bit pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[c % 8];
        return ($urandom_range(0, 2) != 0);
    endfunction

    // Caller must be at #1 after a rising edge; returns at #1 into the DONE cycle.
    task automatic run_cmd(input int b, input int n, input bit brev, input int mode, input int restart_at);
        int cyc;
        bit prev_stall, stall_now, prev_last;
        logic [DW-1:0] prev_data;
        got_data.delete(); got_last.delete(); got_addr.delete();
        first_busy = -1; first_enb = -1; first_valid = -1; last_cyc = -1; done_cyc = -1;
        web_bad = 0; unstable = 0; ovf = 0; stall_enb = 0; n_enb = 0; n_pop = 0; valid_cnt = 0;
        busy_at_done = 1'b1; timed_out = 1'b0;
        prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
        start = 1'b1; base_addr = AW'(b); len = (AW+1)'(n); bitrev = brev;
        cyc = 0;
        m_ready = ready_for(mode, 0);
        while (1) begin
            @(negedge clk);
            stall_now = m_valid && !m_ready;
            if (busy && first_busy < 0) first_busy = cyc;
            if (web !== 1'b0) web_bad++;
            if (m_valid) valid_cnt++;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (enb && stall_now && prev_stall) stall_enb++;
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) unstable++;
            if (n_enb - n_pop > 2) ovf++;
            if (enb) begin
                got_addr.push_back(addrb);
                n_enb++;
                if (first_enb < 0) first_enb = cyc;
            end
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                n_pop++;
                if (m_last) last_cyc = cyc;
            end
            prev_stall = stall_now; prev_data = m_data; prev_last = m_last;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (cyc == restart_at) begin
                start = 1'b1; base_addr = 4'd5; len = 5'd3; bitrev = ~brev;
            end
            if (done) begin
                done_cyc = cyc;
                busy_at_done = busy;
                break;
            end
            if (cyc > 300) begin
                timed_out = 1'b1;
                break;
            end
            m_ready = ready_for(mode, cyc);
        end
        start = 1'b0;
        n_run++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL cmd_timeout: no DONE within %0d cycles (base=%0d len=%0d)", cyc, b, n);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; bitrev = 1'b0; m_ready = 1'b0;
        for (int a = 0; a < 16; a++) mem[a] = DW'(a);
        #3;
        n_run++;
        if ({enb, web, addrb, m_valid, m_data, m_last, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: enb=%b web=%b addrb=%0d valid=%b data=%0d last=%b busy=%b done=%b, want all 0",
                     enb, web, addrb, m_valid, m_data, m_last, busy, done);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_run++;
        if ({enb, m_valid, busy, done} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_idle: enb=%b valid=%b busy=%b done=%b after release, want 0", enb, m_valid, busy, done);
        end
    endtask

    task automatic test_linear;
        int e;
        run_cmd(0, 16, 1'b0, 0, -1);
        e = seq_errors(0, 16, 1'b0);
        n_run++; if (e !== 0) begin n_fail++; $display("FAIL linear_seq: %0d errors, want 0", e); end
        n_run++; if (first_busy !== 1 || first_enb !== 1) begin n_fail++;
            $display("FAIL linear_start: busy@%0d enb@%0d, want 1/1", first_busy, first_enb); end
        n_run++; if (first_valid !== 3) begin n_fail++; $display("FAIL linear_first_valid: %0d, want 3", first_valid); end
        n_run++; if (last_cyc !== 18 || done_cyc !== 19) begin n_fail++;
            $display("FAIL linear_end: last@%0d done@%0d, want 18/19", last_cyc, done_cyc); end
        n_run++; if (valid_cnt !== 16) begin n_fail++; $display("FAIL linear_no_bubbles: valid cycles %0d, want 16", valid_cnt); end
        n_run++; if (web_bad !== 0 || busy_at_done !== 1'b0) begin n_fail++;
            $display("FAIL linear_web_busy: web_high=%0d busy_at_done=%b, want 0/0", web_bad, busy_at_done); end
        @(posedge clk); #1;
        n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL linear_done_pulse: done=%b one cycle later, want 0", done); end
    endtask

    task automatic test_bitrev;
        int e;
        logic [DW-1:0] ref_order [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        @(posedge clk); #1;
        run_cmd(0, 16, 1'b1, 0, -1);
        e = seq_errors(0, 16, 1'b1);
        for (int k = 0; k < 16 && k < got_data.size(); k++) if (got_data[k] !== ref_order[k]) e++;
        n_run++; if (e !== 0) begin n_fail++; $display("FAIL bitrev_seq: %0d errors, want 0", e); end
    endtask

    task automatic test_wrap;
        int e;
        @(posedge clk); #1;
        run_cmd(14, 4, 1'b0, 0, -1);
        e = seq_errors(14, 4, 1'b0);
        n_run++; if (e !== 0) begin n_fail++; $display("FAIL wrap_seq: %0d errors, want 0", e); end
        n_run++; if (got_data.size() != 4 || got_data[3] !== 16'd1 || got_addr[2] !== 4'd0) begin n_fail++;
            $display("FAIL wrap_tail: words=%0d, want 4 ending in 1 with address 0 third", got_data.size()); end
    endtask

    task automatic test_stall;
        int e;
        @(posedge clk); #1;
        run_cmd(0, 16, 1'b0, 1, -1);
        e = seq_errors(0, 16, 1'b0);
        n_run++; if (e !== 0) begin n_fail++; $display("FAIL stall_seq: %0d errors, want 0", e); end
        n_run++; if (unstable !== 0) begin n_fail++; $display("FAIL stall_hold: %0d unstable cycles, want 0", unstable); end
        n_run++; if (stall_enb !== 0 || ovf !== 0) begin n_fail++;
            $display("FAIL stall_backpressure: enb_in_stall=%0d overflow=%0d, want 0/0", stall_enb, ovf); end
    endtask

    task automatic test_len_zero;
        @(posedge clk); #1;
        run_cmd(7, 0, 1'b0, 0, -1);
        n_run++; if (done_cyc !== 1) begin n_fail++; $display("FAIL len0_done: done@%0d, want 1", done_cyc); end
        n_run++; if (n_enb !== 0 || valid_cnt !== 0 || first_busy !== -1) begin n_fail++;
            $display("FAIL len0_quiet: enb=%0d valid=%0d busy@%0d, want 0/0/-1", n_enb, valid_cnt, first_busy); end
    endtask

    task automatic test_start_while_busy;
        int e;
        @(posedge clk); #1;
        run_cmd(2, 6, 1'b0, 0, 4);
        e = seq_errors(2, 6, 1'b0);
        n_run++; if (e !== 0 || done_cyc !== 9) begin n_fail++;
            $display("FAIL busy_start_ignored: %0d errors done@%0d, want 0 and 9", e, done_cyc); end
    endtask

    task automatic test_back_to_back;
        int e, b, n;
        bit brev;
        @(posedge clk); #1;
        for (int t = 0; t < 8; t++) begin
            for (int a = 0; a < 16; a++) mem[a] = DW'($urandom);
            b = $urandom_range(0, 15);
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 16);
            brev = $urandom_range(0, 1);
            run_cmd(b, n, brev, 2, -1);
            e = seq_errors(b, n, brev);
            n_run++; if (e !== 0 || unstable !== 0 || ovf !== 0 || stall_enb !== 0) begin n_fail++;
                $display("FAIL random_cmd%0d: base=%0d len=%0d brev=%b errors=%0d unstable=%0d ovf=%0d stall_enb=%0d, want 0",
                         t, b, n, brev, e, unstable, ovf, stall_enb); end
        end
        for (int a = 0; a < 16; a++) mem[a] = DW'(a);
    endtask

    task automatic test_reset_mid;
        int pops, bad, e;
        @(posedge clk); #1;
        start = 1'b1; base_addr = '0; len = 5'd16; bitrev = 1'b0; m_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        pops = 0;
        for (int c = 0; c < 40 && pops < 5; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) pops++;
        end
        #1 rst_n = 1'b0;
        #1;
        n_run++;
        if ({enb, web, addrb, m_valid, m_data, m_last, busy, done} !== '0 || pops != 5) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: pops=%0d enb=%b addrb=%0d valid=%b data=%0d busy=%b, want 5 then all 0",
                     pops, enb, addrb, m_valid, m_data, busy);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (enb || m_valid || busy) bad++;
        end
        n_run++; if (bad !== 0) begin n_fail++; $display("FAIL reset_mid_quiet: %0d active cycles after release, want 0", bad); end
        @(posedge clk); #1;
        run_cmd(3, 2, 1'b0, 0, -1);
        e = seq_errors(3, 2, 1'b0);
        n_run++; if (e !== 0 || got_data.size() != 2 || got_data[0] !== 16'd3) begin n_fail++;
            $display("FAIL reset_mid_restart: %0d errors, %0d words, want 0 errors and words 3,4", e, got_data.size()); end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_bitrev();
        test_wrap();
        test_stall();
        test_len_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
